rnm_ramp_driver: RTL and testbench

//  Digital-to-RNM output driver: the reverse of the RNM inverter, which turns real levels into a logic decision.

---
 rtl/rnm_ramp_driver.sv | 143 ++++++++++++++
 tb/tb_rnm_ramp_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rnm_ramp_driver.sv
// Logic-to-real output driver: samples din on clk and drives vout with
// per-edge inertial delay and linear rise/fall ramps clamped at the rails.
module rnm_ramp_driver #(
    parameter real VDD           = 1.8,
    parameter real VSS           = 0.0,
    parameter real VTH           = 0.9,
    parameter int  DLY_RISE_CYC  = 2,
    parameter int  DLY_FALL_CYC  = 2,
    parameter int  RAMP_RISE_CYC = 4,
    parameter int  RAMP_FALL_CYC = 4,
    parameter int  CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output real              vout,
    output logic             dout,
    output logic             settled,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam real UP  = (VDD - VSS) / $itor(RAMP_RISE_CYC);
    localparam real DN  = (VDD - VSS) / $itor(RAMP_FALL_CYC);
    localparam real EPS = 1.0e-9;

    localparam logic [15:0] DLY_R_LD = 16'(DLY_RISE_CYC);
    localparam logic [15:0] DLY_F_LD = 16'(DLY_FALL_CYC);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        st_low,
        st_dly_r,
        st_ramp_r,
        st_high,
        st_dly_f,
        st_ramp_f
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    real         vout_n;
    logic        inc;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vout_n  = vout;
        inc     = 1'b0;
        unique case (state)
            st_low: begin
                vout_n = VSS;
                if (din) begin
                    if (DLY_RISE_CYC == 0) begin
                        state_n = st_ramp_r;
                    end else begin
                        state_n = st_dly_r;
                        cnt_n   = DLY_R_LD;
                    end
                end
            end
            st_dly_r: begin
                if (!din) begin
                    state_n = st_low;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt - 16'd1;
                    if (cnt <= 16'd1) begin
                        state_n = st_ramp_r;
                        cnt_n   = 16'd0;
                    end
                end
            end
            st_ramp_r: begin
                if (!din) begin
                    state_n = st_ramp_f;
                end else if (vout + UP >= VDD - EPS) begin
                    vout_n  = VDD;
                    state_n = st_high;
                    inc     = 1'b1;
                end else begin
                    vout_n = vout + UP;
                end
            end
            st_high: begin
                vout_n = VDD;
                if (!din) begin
                    if (DLY_FALL_CYC == 0) begin
                        state_n = st_ramp_f;
                    end else begin
                        state_n = st_dly_f;
                        cnt_n   = DLY_F_LD;
                    end
                end
            end
            st_dly_f: begin
                if (din) begin
                    state_n = st_high;
                    cnt_n   = 16'd0;
                end else begin
                    cnt_n = cnt - 16'd1;
                    if (cnt <= 16'd1) begin
                        state_n = st_ramp_f;
                        cnt_n   = 16'd0;
                    end
                end
            end
            st_ramp_f: begin
                if (din) begin
                    state_n = st_ramp_r;
                end else if (vout - DN <= VSS + EPS) begin
                    vout_n  = VSS;
                    state_n = st_low;
                    inc     = 1'b1;
                end else begin
                    vout_n = vout - DN;
                end
            end
            default: begin
                state_n = st_low;
                vout_n  = VSS;
                cnt_n   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= st_low;
            cnt      <= 16'd0;
            vout     <= VSS;
            edge_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            vout  <= vout_n;
            if (inc) edge_cnt <= edge_cnt + ONE;
        end
    end

    assign dout    = (vout >= VTH);
    assign settled = (state == st_low) || (state == st_high);

endmodule

// File: tb/tb_rnm_ramp_driver.sv
// Directed bench for rnm_ramp_driver: rise/fall latency, glitch filter,
// ramp reversal, async reset mid-ramp and edge counter wrap.
module tb_rnm_ramp_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    real         vout, vout2;
    logic        dout, dout2;
    logic        settled, settled2;
    logic [15:0] edge_cnt;
    logic [1:0]  edge_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rnm_ramp_driver u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .vout     (vout),
        .dout     (dout),
        .settled  (settled),
        .edge_cnt (edge_cnt)
    );

    rnm_ramp_driver #(.CNT_W(2)) u_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .vout     (vout2),
        .dout     (dout2),
        .settled  (settled2),
        .edge_cnt (edge_cnt2)
    );

    task automatic chk(input string tag, input real got, input real exp);
        n_chk++;
        if ((got - exp) < 1.0e-6 && (exp - got) < 1.0e-6) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %f exp %f", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    real rise_v [7] = '{0.0, 0.0, 0.0, 0.45, 0.9, 1.35, 1.8};
    real fall_v [7] = '{1.8, 1.8, 1.8, 1.35, 0.9, 0.45, 0.0};
    int  wrap_e [5] = '{1, 2, 3, 0, 1};
    int  ec;

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        #2;
        chk("rst_vout", vout, 0.0);
        chk("rst_settled", real'(settled), 1.0);
        chk("rst_cnt", real'(edge_cnt), 0.0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("low_idle", vout, 0.0);

        // rise
        din = 1'b1;
        for (int e = 0; e < 7; e++) begin
            tick();
            chk($sformatf("rise_v%0d", e), vout, rise_v[e]);
            if (e == 3) chk("rise_settled3", real'(settled), 0.0);
        end
        chk("rise_settled", real'(settled), 1.0);
        chk("rise_cnt", real'(edge_cnt), 1.0);
        chk("rise_dout", real'(dout), 1.0);

        // fall
        din = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            chk($sformatf("fall_v%0d", e), vout, fall_v[e]);
            if (e == 3) chk("fall_dout3", real'(dout), 1.0);
            if (e >= 5) chk($sformatf("fall_dout%0d", e), real'(dout), 0.0);
        end
        chk("fall_settled", real'(settled), 1.0);
        chk("fall_cnt", real'(edge_cnt), 2.0);

        // one-cycle glitch is swallowed
        ec = int'(edge_cnt);
        din = 1'b1;
        tick();
        chk("glitch_dly", real'(settled), 0.0);
        din = 1'b0;
        tick();
        chk("glitch_settled", real'(settled), 1.0);
        chk("glitch_vout", vout, 0.0);
        for (int e = 0; e < 5; e++) tick();
        chk("glitch_vout_late", vout, 0.0);
        chk("glitch_cnt", real'(edge_cnt), real'(ec));

        // reversal mid-rise
        din = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        chk("rev_v3", vout, 0.45);
        din = 1'b0;
        tick();
        chk("rev_hold", vout, 0.45);
        chk("rev_settled4", real'(settled), 0.0);
        chk("rev_dout4", real'(dout), 0.0);
        tick();
        chk("rev_v5", vout, 0.0);
        chk("rev_settled5", real'(settled), 1.0);
        chk("rev_cnt", real'(edge_cnt), real'(ec + 1));
        chk("rev_dout5", real'(dout), 0.0);

        // async reset mid-ramp
        din = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        chk("pre_rst_v", vout, 0.9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vout", vout, 0.0);
        chk("mid_rst_settled", real'(settled), 1.0);
        chk("mid_rst_cnt", real'(edge_cnt), 0.0);
        chk("mid_rst_cnt2", real'(edge_cnt2), 0.0);
        din = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_vout", vout, 0.0);

        // counter wrap on the 2-bit instance
        for (int r = 0; r < 5; r++) begin
            din = (r % 2 == 0);
            for (int e = 0; e < 7; e++) tick();
            chk($sformatf("wrap%0d", r), real'(edge_cnt2), real'(wrap_e[r]));
        end
        chk("wrap_wide", real'(edge_cnt), 5.0);
        chk("wrap_v", vout2, 1.8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
